touch_region_selector: RTL and testbench
========================================

Name: touch_region_selector

Overview:
- Sits between Touch_Panel_Controller and the colour-bar generator in the LTM top level.
- Averages a burst of touch coordinate samples and maps the averaged point to one of 8 screen regions (2 rows x 4 columns).
- Advances that region's 3-bit colour code once per physical touch.
- Drives the 8-entry region colour table the colour-bar generator reads.

Parameters:
- AVG_LOG2, 2, log2 of samples averaged per touch (N = 2^AVG_LOG2).
- RELEASE_CYCLES, 50000, consecutive Touch_En-low clocks that qualify a release (1 ms at 50 MHz).

Ports:
- Clock  in  1  system clock, 50 MHz.
- Resetn  in  1  asynchronous, active-low reset.
- Touch_En  in  1  pen-down level from the touch panel controller.
- Coord_En  in  1  one-cycle strobe; X_Coord/Y_Coord valid this cycle.
- X_Coord  in  12  raw X sample.
- Y_Coord  in  12  raw Y sample.
- Clear  in  1  synchronous reset of table and FSM.
- Region_RGB  out  3 x [7:0]  colour code per region; bit0 Red, bit1 Blue, bit2 Green.
- Sel_Region  out  3  last committed region index.
- Sel_Valid  out  1  one-cycle pulse on commit.
- Busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (Resetn low, asynchronous):
  - Region_RGB[i] = i for i = 0..7.
  - Sel_Region = 0, Sel_Valid = 0, Busy = 0.
  - State = IDLE; accumulator, sample count and release counter = 0.
- Sample accept: Coord_En && Touch_En in IDLE or ACCUM. Coord_En with Touch_En low is ignored.
- Accumulator is 12+AVG_LOG2 bits wide, so there is no overflow. avg = sum >> AVG_LOG2 (truncating).
- Region index = {avgY[11], avgX[11:10]}:
  - Row 0 is Y < 0x800.
  - Column is avgX / 1024.
- State IDLE: on a sample accept, load accumulator with the sample, count = 1, go to ACCUM.
- State ACCUM:
  - Each accepted sample is added to the accumulator and increments count.
  - On the edge accepting sample N, register Sel_Region from the final (sum + sample) >> AVG_LOG2 and go to COMMIT.
  - If N = 1, IDLE goes straight to COMMIT.
  - Release qualified before N samples: abort to IDLE, no commit, accumulator cleared.
- State COMMIT (exactly 1 cycle):
  - Sel_Valid = 1.
  - At the closing edge, Region_RGB[Sel_Region] <= Region_RGB[Sel_Region] + 1 mod 8 (7 wraps to 0), and state goes to HOLD.
  - Table update is visible 2 edges after the Nth sample is accepted.
- State HOLD:
  - Coord_En is ignored.
  - Go to IDLE when release is qualified. Only one commit per pen-down.
- Release counter:
  - Increments while Touch_En = 0, saturating at RELEASE_CYCLES.
  - Clears to 0 on any cycle Touch_En = 1.
  - Release is qualified when count == RELEASE_CYCLES.
  - Counter width is $clog2(RELEASE_CYCLES+1).
  - Counter is cleared on every entry to IDLE.
- Clear:
  - Highest priority; overrides COMMIT in the same cycle (no table increment).
  - Next edge: table = reset values, state = IDLE, accumulator = 0, Sel_Valid = 0, Sel_Region = 0.
- Resetn mid-operation: immediate return to reset values; no partial commit survives.
- Region_RGB, Sel_Region, Sel_Valid and Busy are all registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package (ltm_pkg):
  - REGION_COUNT = 8, COORD_W = 12.
  - typedef region_idx_t (3 bits), typedef colour_code_t (3 bits).
  - FSM enum {IDLE, ACCUM, COMMIT, HOLD}.
- One sub-module: touch_release_timer.
  - Ports: Clock, Resetn, Clear, Touch_En, Release_Qualified.
  - Parameter: RELEASE_CYCLES.
  - Reused by future touch-driven blocks.

Test Plan (AVG_LOG2 = 2, RELEASE_CYCLES = 8):
- Reset → Region_RGB = {0,1,2,3,4,5,6,7}; Sel_Valid = 0; Busy = 0.
- 4 accepted samples X=0x500, Y=0x900 → one Sel_Valid pulse with Sel_Region = 5; Region_RGB[5] goes 5 → 6; other entries unchanged.
- Samples X=0x3F0,0x3F0,0x410,0x410 with Y=0x100 → avgX = 0x400; Sel_Region = 1 (not 0); Region_RGB[1] = 2.
- Two full touches at X=0xC00, Y=0xC00 → Region_RGB[7] goes 7 → 0 → 1 (wrap check).
- After commit:
  - Hold Touch_En high with 10 Coord_En strobes → no further Sel_Valid.
  - Then Touch_En low 7 cycles, high 1 cycle, low 8 cycles → Busy drops only after the final 8th low cycle.
- 2 samples then Touch_En low 8 cycles → IDLE, no Sel_Valid, table unchanged.
- Clear asserted during COMMIT → no increment, table restored, Busy = 0 next cycle.
- Resetn pulsed in ACCUM → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ltm_pkg.sv
// rtl/ltm_pkg.sv - shared types and constants for LTM touch-driven blocks
package ltm_pkg;

  localparam int REGION_COUNT = 8;
  localparam int COORD_W      = 12;

  typedef logic [2:0] region_idx_t;
  typedef logic [2:0] colour_code_t;

  typedef enum logic [1:0] {IDLE, ACCUM, COMMIT, HOLD} sel_state_e;

  // Screen is 2 rows x 4 columns: row from the Y MSB, column from the top two X bits.
  function automatic region_idx_t region_of(input logic y_msb, input logic [1:0] x_col);
    return {y_msb, x_col};
  endfunction

endpackage

// File: rtl/touch_release_timer.sv
// rtl/touch_release_timer.sv - qualifies a pen release after RELEASE_CYCLES idle clocks
module touch_release_timer #(
  parameter int RELEASE_CYCLES = 50000
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic Clear,
  input  logic Touch_En,
  output logic Release_Qualified
);

  localparam int CNT_W = $clog2(RELEASE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RELEASE_CYCLES);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (Clear || Touch_En) begin
      count_d = '0;
    end else if (count_q != CNT_MAX) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Release_Qualified = (count_q == CNT_MAX);

endmodule

// File: rtl/touch_region_selector.sv
// rtl/touch_region_selector.sv - averages a touch burst and steps that screen region's colour
module touch_region_selector
  import ltm_pkg::*;
#(
  parameter int AVG_LOG2       = 2,
  parameter int RELEASE_CYCLES = 50000
) (
  input  logic                             Clock,
  input  logic                             Resetn,
  input  logic                             Touch_En,
  input  logic                             Coord_En,
  input  logic [COORD_W-1:0]               X_Coord,
  input  logic [COORD_W-1:0]               Y_Coord,
  input  logic                             Clear,
  output colour_code_t [REGION_COUNT-1:0]  Region_RGB,
  output region_idx_t                      Sel_Region,
  output logic                             Sel_Valid,
  output logic                             Busy
);

  localparam int ACC_W = COORD_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] N_SAMPLES = CNT_W'(1 << AVG_LOG2);

  sel_state_e                      state_q, state_d;
  logic [ACC_W-1:0]                acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [ACC_W-1:0]                sum_x, sum_y;
  logic [CNT_W-1:0]                cnt_q, cnt_d, cnt_next;
  region_idx_t                     sel_region_q, sel_region_d;
  colour_code_t [REGION_COUNT-1:0] rgb_q, rgb_d;
  logic                            accept;
  logic                            release_qual;
  logic                            timer_clear;

  assign accept = Coord_En && Touch_En && (state_q == IDLE || state_q == ACCUM);

  // IDLE starts from an empty sum so the first sample loads rather than adds.
  assign sum_x    = ((state_q == ACCUM) ? acc_x_q : '0) + ACC_W'(X_Coord);
  assign sum_y    = ((state_q == ACCUM) ? acc_y_q : '0) + ACC_W'(Y_Coord);
  assign cnt_next = ((state_q == ACCUM) ? cnt_q : '0) + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    acc_x_d      = acc_x_q;
    acc_y_d      = acc_y_q;
    cnt_d        = cnt_q;
    sel_region_d = sel_region_q;
    rgb_d        = rgb_q;
    if (Clear) begin
      state_d      = IDLE;
      acc_x_d      = '0;
      acc_y_d      = '0;
      cnt_d        = '0;
      sel_region_d = '0;
      for (int i = 0; i < REGION_COUNT; i++) rgb_d[i] = colour_code_t'(i);
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (state_q == ACCUM && release_qual) begin
            state_d = IDLE;
            acc_x_d = '0;
            acc_y_d = '0;
            cnt_d   = '0;
          end else if (accept) begin
            if (cnt_next == N_SAMPLES) begin
              // The top bits of the sum are the top bits of the truncated average.
              sel_region_d = region_of(sum_y[ACC_W-1], sum_x[ACC_W-1 -: 2]);
              state_d      = COMMIT;
              acc_x_d      = '0;
              acc_y_d      = '0;
              cnt_d        = '0;
            end else begin
              state_d = ACCUM;
              acc_x_d = sum_x;
              acc_y_d = sum_y;
              cnt_d   = cnt_next;
            end
          end
        end
        COMMIT: begin
          rgb_d[sel_region_q] = rgb_q[sel_region_q] + colour_code_t'(1);
          state_d             = HOLD;
        end
        HOLD: begin
          if (release_qual) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q      <= IDLE;
      acc_x_q      <= '0;
      acc_y_q      <= '0;
      cnt_q        <= '0;
      sel_region_q <= '0;
      for (int i = 0; i < REGION_COUNT; i++) rgb_q[i] <= colour_code_t'(i);
    end else begin
      state_q      <= state_d;
      acc_x_q      <= acc_x_d;
      acc_y_q      <= acc_y_d;
      cnt_q        <= cnt_d;
      sel_region_q <= sel_region_d;
      rgb_q        <= rgb_d;
    end
  end

  // Restart release timing on every return to IDLE so one release ends one touch.
  assign timer_clear = Clear || (state_d == IDLE && state_q != IDLE);

  touch_release_timer #(
    .RELEASE_CYCLES(RELEASE_CYCLES)
  ) u_release_timer (
    .Clock             (Clock),
    .Resetn            (Resetn),
    .Clear             (timer_clear),
    .Touch_En          (Touch_En),
    .Release_Qualified (release_qual)
  );

  assign Region_RGB = rgb_q;
  assign Sel_Region = sel_region_q;
  assign Sel_Valid  = (state_q == COMMIT);
  assign Busy       = (state_q != IDLE);

endmodule

// File: tb/tb_touch_region_selector.sv
// tb/tb_touch_region_selector.sv - randomized self-checking bench for touch_region_selector
module tb_touch_region_selector;
  import ltm_pkg::*;

  logic Clock = 1'b0;
  logic Resetn = 1'b0;
  logic Touch_En = 1'b0;
  logic Coord_En = 1'b0;
  logic Clear = 1'b0;
  logic [11:0] X_Coord = '0;
  logic [11:0] Y_Coord = '0;
  colour_code_t [REGION_COUNT-1:0] Region_RGB;
  region_idx_t Sel_Region;
  logic Sel_Valid;
  logic Busy;

  int checks = 0;
  int errors = 0;
  int pulse_count = 0;
  int exp_pulses = 0;
  int model_rgb[8];

  touch_region_selector #(
    .AVG_LOG2(2),
    .RELEASE_CYCLES(8)
  ) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Touch_En   (Touch_En),
    .Coord_En   (Coord_En),
    .X_Coord    (X_Coord),
    .Y_Coord    (Y_Coord),
    .Clear      (Clear),
    .Region_RGB (Region_RGB),
    .Sel_Region (Sel_Region),
    .Sel_Valid  (Sel_Valid),
    .Busy       (Busy)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) if (Sel_Valid === 1'b1) pulse_count++;

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) model_rgb[i] = i;
  endfunction

  // Screen geometry straight from the region map: 4 columns of 1024 px, row split at 2048.
  function automatic int region_model(input int sx, input int sy);
    int ax, ay;
    ax = sx / 4;
    ay = sy / 4;
    return ((ay >= 2048) ? 4 : 0) + ax / 1024;
  endfunction

  task automatic send(input int x, input int y, input bit gap, input bit junk);
    if (gap) begin
      Touch_En = 1'b1; Coord_En = 1'b0; step();
    end
    if (junk) begin
      Touch_En = 1'b0; Coord_En = 1'b1;
      X_Coord = 12'($urandom_range(0, 4095)); Y_Coord = 12'($urandom_range(0, 4095));
      step();
    end
    Touch_En = 1'b1; Coord_En = 1'b1;
    X_Coord = 12'(x); Y_Coord = 12'(y);
    step();
    Coord_En = 1'b0;
  endtask

  task automatic release_pen();
    Touch_En = 1'b0; Coord_En = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_touch(input int xs[4], input int ys[4], input bit rnd, input string name);
    int sx, sy, r;
    sx = 0; sy = 0;
    for (int i = 0; i < 4; i++) begin
      sx += xs[i]; sy += ys[i];
      send(xs[i], ys[i], rnd && ($urandom_range(0, 2) == 0), rnd && ($urandom_range(0, 3) == 0));
    end
    r = region_model(sx, sy);
    checks++;
    if (Sel_Valid !== 1'b1 || Sel_Region !== 3'(r)) begin
      errors++;
      $display("FAIL %s commit: valid=%b region=%0d, required valid=1 region=%0d", name, Sel_Valid, Sel_Region, r);
    end
    exp_pulses++;
    model_rgb[r] = (model_rgb[r] + 1) % 8;
    step();
    checks++;
    if (Sel_Valid !== 1'b0 || Busy !== 1'b1) begin
      errors++;
      $display("FAIL %s hold: valid=%b busy=%b, required valid=0 busy=1", name, Sel_Valid, Busy);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (Region_RGB[k] !== 3'(model_rgb[k])) begin
        errors++;
        $display("FAIL %s rgb[%0d]: got %0d, required %0d", name, k, Region_RGB[k], model_rgb[k]);
      end
    end
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    repeat (2) step();
    model_reset();
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (Region_RGB[k] !== 3'(model_rgb[k])) begin
        errors++;
        $display("FAIL reset rgb[%0d]: got %0d, required %0d", k, Region_RGB[k], model_rgb[k]);
      end
    end
    checks++;
    if (Sel_Valid !== 1'b0 || Busy !== 1'b0 || Sel_Region !== 3'd0) begin
      errors++;
      $display("FAIL reset outputs: valid=%b busy=%b region=%0d, required 0 0 0", Sel_Valid, Busy, Sel_Region);
    end
    Resetn = 1'b1;
    step();
  endtask

  task automatic test_directed();
    test_touch('{12'h500, 12'h500, 12'h500, 12'h500}, '{12'h900, 12'h900, 12'h900, 12'h900}, 1'b0, "single");
    release_pen();
    test_touch('{12'h3F0, 12'h3F0, 12'h410, 12'h410}, '{12'h100, 12'h100, 12'h100, 12'h100}, 1'b0, "col_boundary");
    release_pen();
    test_touch('{12'hC00, 12'hC00, 12'hC00, 12'hC00}, '{12'hC00, 12'hC00, 12'hC00, 12'hC00}, 1'b0, "wrap_a");
    release_pen();
    test_touch('{12'hC00, 12'hC00, 12'hC00, 12'hC00}, '{12'hC00, 12'hC00, 12'hC00, 12'hC00}, 1'b0, "wrap_b");
  endtask

  task automatic test_hold_release();
    int base;
    base = pulse_count;
    for (int i = 0; i < 10; i++) send($urandom_range(0, 4095), $urandom_range(0, 4095), 1'b0, 1'b0);
    checks++;
    if (pulse_count !== base || Busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_strobes: pulses=%0d busy=%b, required pulses=%0d busy=1", pulse_count, Busy, base);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (Region_RGB[k] !== 3'(model_rgb[k])) begin
        errors++;
        $display("FAIL hold_strobes rgb[%0d]: got %0d, required %0d", k, Region_RGB[k], model_rgb[k]);
      end
    end
    Touch_En = 1'b0; repeat (7) step();
    Touch_En = 1'b1; step();
    Touch_En = 1'b0; repeat (7) step();
    checks++;
    if (Busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_glitch: busy=%b after 7 lows, required 1", Busy);
    end
    repeat (2) step();
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: busy=%b after full release, required 0", Busy);
    end
  endtask

  task automatic test_abort();
    int base;
    base = pulse_count;
    send(12'hFFF, 12'hFFF, 1'b0, 1'b0);
    send(12'hFFF, 12'hFFF, 1'b0, 1'b0);
    release_pen();
    checks++;
    if (Busy !== 1'b0 || pulse_count !== base) begin
      errors++;
      $display("FAIL abort: busy=%b pulses=%0d, required busy=0 pulses=%0d", Busy, pulse_count, base);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (Region_RGB[k] !== 3'(model_rgb[k])) begin
        errors++;
        $display("FAIL abort rgb[%0d]: got %0d, required %0d", k, Region_RGB[k], model_rgb[k]);
      end
    end
    test_touch('{12'h000, 12'h000, 12'h000, 12'h000}, '{12'h000, 12'h000, 12'h000, 12'h000}, 1'b0, "after_abort");
    release_pen();
  endtask

  task automatic test_random();
    int xs[4], ys[4];
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 4; i++) begin
        xs[i] = $urandom_range(0, 4095);
        ys[i] = $urandom_range(0, 4095);
      end
      test_touch(xs, ys, 1'b1, "random");
      release_pen();
      checks++;
      if (Busy !== 1'b0) begin
        errors++;
        $display("FAIL random_release: busy=%b, required 0", Busy);
      end
    end
  endtask

  task automatic test_clear_commit();
    for (int i = 0; i < 4; i++) send(12'h900, 12'h100, 1'b0, 1'b0);
    checks++;
    if (Sel_Valid !== 1'b1) begin
      errors++;
      $display("FAIL clear_setup: valid=%b, required 1", Sel_Valid);
    end
    exp_pulses++;
    Clear = 1'b1; step(); Clear = 1'b0;
    model_reset();
    checks++;
    if (Busy !== 1'b0 || Sel_Valid !== 1'b0 || Sel_Region !== 3'd0) begin
      errors++;
      $display("FAIL clear: busy=%b valid=%b region=%0d, required 0 0 0", Busy, Sel_Valid, Sel_Region);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (Region_RGB[k] !== 3'(model_rgb[k])) begin
        errors++;
        $display("FAIL clear rgb[%0d]: got %0d, required %0d", k, Region_RGB[k], model_rgb[k]);
      end
    end
    release_pen();
  endtask

  task automatic test_reset_mid();
    test_touch('{12'h400, 12'h400, 12'h400, 12'h400}, '{12'h000, 12'h000, 12'h000, 12'h000}, 1'b0, "pre_reset");
    release_pen();
    send(12'hFFF, 12'hFFF, 1'b0, 1'b0);
    send(12'hFFF, 12'hFFF, 1'b0, 1'b0);
    Resetn = 1'b0;
    #2;
    model_reset();
    checks++;
    if (Busy !== 1'b0 || Sel_Valid !== 1'b0 || Sel_Region !== 3'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b valid=%b region=%0d, required 0 0 0", Busy, Sel_Valid, Sel_Region);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (Region_RGB[k] !== 3'(model_rgb[k])) begin
        errors++;
        $display("FAIL async_reset rgb[%0d]: got %0d, required %0d", k, Region_RGB[k], model_rgb[k]);
      end
    end
    step();
    Resetn = 1'b1;
    release_pen();
    test_touch('{12'h800, 12'h800, 12'h800, 12'h800}, '{12'h000, 12'h000, 12'h000, 12'h000}, 1'b0, "post_reset");
    release_pen();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_directed();
    test_hold_release();
    test_abort();
    test_random();
    test_clear_commit();
    test_reset_mid();
    step();
    checks++;
    if (pulse_count !== exp_pulses) begin
      errors++;
      $display("FAIL pulse_total: got %0d, required %0d", pulse_count, exp_pulses);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
